// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   PC_STEP       : byte distance between consecutive instructions
//   PC_AHEAD      : offset of the PC value seen by an instruction reading R15
//   NOP_INSTR     : instruction word used for a flushed IF/ID register
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_STEP   = 4;
  localparam int unsigned PC_AHEAD  = 8;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_stage_mux2.sv
// Mux2
//   Generic two-input multiplexer.
//   d0_i, d1_i : data inputs (BITS wide)
//   sel_i      : 0 selects d0_i, 1 selects d1_i
//   y_o        : selected data
module Mux2 #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] d0_i,
  input  logic [BITS-1:0] d1_i,
  input  logic            sel_i,
  output logic [BITS-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Fetch stage of the 32-bit ARM pipeline. Owns the PC, drives a ready-based
//   instruction-memory handshake, applies redirects from execute/writeback
//   and loads the IF/ID register feeding decode.
//   CLK, RESET            : clock, asynchronous active-low reset
//   StallF, StallD, FlushD: hazard-unit controls
//   BranchTakenE/ALUResultE : execute redirect (wins over writeback)
//   PCSrcW/ResultW        : writeback redirect (write to R15)
//   IMemReqF/IMemAddrF    : fetch request and address
//   IMemReadyF/IMemRDataF : memory response
//   InstrD/PCPlus8D/ValidD: IF/ID register outputs
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            BranchTakenE,
  input  logic [BITS-1:0] ALUResultE,
  input  logic            PCSrcW,
  input  logic [BITS-1:0] ResultW,
  output logic            IMemReqF,
  output logic [BITS-1:0] IMemAddrF,
  input  logic            IMemReadyF,
  input  logic [BITS-1:0] IMemRDataF,
  output logic [BITS-1:0] InstrD,
  output logic [BITS-1:0] PCPlus8D,
  output logic            ValidD
);

  fetch_state_t    state_q, state_d;
  logic [BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0] drop_addr_q, drop_addr_d;
  logic [BITS-1:0] skid_q, skid_d;
  logic [BITS-1:0] instr_q, instr_d;
  logic [BITS-1:0] pcplus8_q, pcplus8_d;
  logic            valid_q, valid_d;

  logic            stall;
  logic            redirect;
  logic [BITS-1:0] pc_plus4;
  logic [BITS-1:0] pc_plus8;
  logic [BITS-1:0] wb_or_seq;
  logic [BITS-1:0] next_pc;

  logic            pc_en;
  logic            drop_en;
  logic            skid_en;
  logic            load;
  logic            load_from_skid;

  assign stall    = StallF | StallD;
  assign redirect = BranchTakenE | PCSrcW;
  // Both sums wrap modulo 2^BITS by width truncation.
  assign pc_plus4 = pc_q + BITS'(PC_STEP);
  assign pc_plus8 = pc_q + BITS'(PC_AHEAD);

  // With no redirect both selects are low and the sequential PC passes through;
  // the second mux lets execute override writeback.
  Mux2 #(.BITS(BITS)) u_mux_wb (
    .d0_i  (pc_plus4),
    .d1_i  (ResultW),
    .sel_i (PCSrcW),
    .y_o   (wb_or_seq)
  );

  Mux2 #(.BITS(BITS)) u_mux_ex (
    .d0_i  (wb_or_seq),
    .d1_i  (ALUResultE),
    .sel_i (BranchTakenE),
    .y_o   (next_pc)
  );

  // In DROP the memory still owns the old address, so it is replayed from its
  // own register while PCF is free to take the redirect target.
  assign IMemReqF  = (state_q == WAIT) || (state_q == DROP);
  assign IMemAddrF = (state_q == DROP) ? drop_addr_q : pc_q;

  always_comb begin
    state_d        = state_q;
    pc_en          = 1'b0;
    drop_en        = 1'b0;
    skid_en        = 1'b0;
    load           = 1'b0;
    load_from_skid = 1'b0;
    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        if (redirect) begin
          pc_en = 1'b1;
          if (!IMemReadyF) begin
            drop_en = 1'b1;
            state_d = DROP;
          end
        end else if (IMemReadyF) begin
          if (!stall) begin
            pc_en = 1'b1;
            load  = 1'b1;
          end else begin
            skid_en = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_en   = 1'b1;
          state_d = WAIT;
        end else if (!stall) begin
          pc_en          = 1'b1;
          load           = 1'b1;
          load_from_skid = 1'b1;
          state_d        = WAIT;
        end
      end
      DROP: begin
        if (redirect) pc_en = 1'b1;
        if (IMemReadyF) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d        = pc_en   ? next_pc    : pc_q;
    drop_addr_d = drop_en ? pc_q       : drop_addr_q;
    skid_d      = skid_en ? IMemRDataF : skid_q;
    instr_d     = instr_q;
    pcplus8_d   = pcplus8_q;
    valid_d     = valid_q;
    if (FlushD) begin
      instr_d = BITS'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (load) begin
        // PCF is not advanced while the word sits in the skid register, so
        // pc_plus8 is still correct for a skid load.
        instr_d   = load_from_skid ? skid_q : IMemRDataF;
        pcplus8_d = pc_plus8;
        valid_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      skid_q      <= '0;
      instr_q     <= '0;
      pcplus8_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      skid_q      <= skid_d;
      instr_q     <= instr_d;
      pcplus8_q   <= pcplus8_d;
      valid_q     <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCPlus8D = pcplus8_q;
  assign ValidD   = valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Pipeline fetch stage of the 32-bit ARM core. It owns the PC register and drives a ready-based instruction-memory handshake. It handles redirects from execute (branch taken) and writeback (PC write), and loads the IF/ID register whose outputs feed the decode stage: the instruction, PC+8 for R15 reads, and a valid bit. A small FSM lets the stage tolerate multi-cycle memory, decode stalls and redirects that arrive while a fetch is outstanding.

## Interface
- BITS, 32, datapath and address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- StallF  in  1  hazard unit: hold PC and fetch
- StallD  in  1  hazard unit: hold IF/ID register
- FlushD  in  1  hazard unit: bubble IF/ID
- BranchTakenE  in  1  redirect to ALUResultE
- ALUResultE  in  BITS  branch target
- PCSrcW  in  1  redirect to ResultW (write to R15)
- ResultW  in  BITS  writeback target
- IMemReqF  out  1  fetch request
- IMemAddrF  out  BITS  fetch address (= PCF)
- IMemReadyF  in  1  memory returns IMemRDataF this cycle
- IMemRDataF  in  BITS  fetched instruction
- InstrD  out  BITS  IF/ID instruction
- PCPlus8D  out  BITS  IF/ID fetch address + 8
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- stall = StallF | StallD.
- redirect = BranchTakenE | PCSrcW.
- target = ALUResultE if BranchTakenE, else ResultW. Execute wins when both are asserted.
- FSM states and transitions:
  - IDLE: entered on reset. Unconditionally moves to WAIT next cycle. IMemReqF = 0.
  - WAIT: IMemReqF = 1 and IMemAddrF = PCF. The address is held until IMemReadyF.
    - redirect (with or without ready): PCF <= target. Any returned data is discarded. Next state is DROP if not ready, WAIT if ready.
    - ready & !stall: IF/ID loads {IMemRDataF, PCF+8, 1}. PCF <= PCF+4. Stay in WAIT.
    - ready & stall: data goes to the skid register; go to HOLD.
  - HOLD: IMemReqF = 0.
    - redirect: discard skid; PCF <= target; go to WAIT.
    - !stall: IF/ID loads from skid; PCF <= PCF+4; go to WAIT.
  - DROP: IMemReqF = 1 with IMemAddrF = the stale address, which is latched in a separate register. The outstanding fetch cannot be cancelled.
    - ready: discard data; go to WAIT.
    - A redirect in DROP updates PCF only.
- IF/ID register behaviour:
  - FlushD has priority: InstrD <= 0, ValidD <= 0, PCPlus8D unchanged.
  - Otherwise StallD holds the register.
  - Otherwise, with no load this cycle, ValidD <= 0 (bubble).
- Arithmetic: PC+4 and PC+8 are modulo 2^BITS. 32'hFFFF_FFFC + 4 wraps to 0. The PC low two bits are taken as given, with no alignment check.

## Timing
- Reset values:
  - PCF = RESET_PC; state = IDLE.
  - IMemReqF = 0; IMemAddrF = RESET_PC.
  - InstrD = 0, PCPlus8D = 0, ValidD = 0.
  - Skid register = 0.
- Zero-wait memory (ready in the request cycle): one instruction per cycle. The instruction requested in cycle N appears on InstrD after edge N+1.
- First request is asserted in the second cycle after RESET deasserts.
- Redirect latency: the target is on IMemAddrF in the cycle after redirect, or one cycle after the stale ready when in DROP.
- IMemAddrF and IMemReqF never change while IMemReqF = 1 and IMemReadyF = 0, except for the WAIT→DROP address latch, which keeps the address stable.
- Reset asserted mid-fetch: everything returns to reset values immediately. Any later stray IMemReadyF in IDLE is ignored.

## Structure
- Shared package `fetch_pkg`:
  - fetch_state_t enum {IDLE, WAIT, HOLD, DROP}
  - PC_STEP = 4
  - PC_AHEAD = 8
  - NOP_INSTR = 32'h0
- Next-PC selection uses two instances of the existing Mux2 (BITS=BITS): PCPlus4 vs ResultW, then that result vs ALUResultE.
- FSM, PC register, skid register and IF/ID register stay in fetch_stage; no other sub-module.

## Test plan
- Reset with RESET_PC=0 and ready tied high, 4 cycles. Required:
  - IMemAddrF sequence 0, 4, 8, 12.
  - PCPlus8D sequence 8, 12, 16.
  - ValidD = 1 from the third cycle.
- Ready delayed 3 cycles per fetch. Required:
  - IMemAddrF is held at 0x4 for all 3 cycles.
  - ValidD pulses once per fetch.
  - InstrD = the returned word.
- StallD asserted for 2 cycles at the same time as ready returns 0xE3A01005 at 0x8. Required:
  - Stage enters HOLD with IMemReqF = 0.
  - After the stall releases, InstrD = 0xE3A01005 and PCPlus8D = 0x10.
  - The next address is 0xC.
- BranchTakenE with ALUResultE = 0x100 while a fetch of 0x20 is outstanding. Required:
  - Stage enters DROP; the 0x20 data is discarded with ValidD = 0.
  - The next request address is 0x100.
- BranchTakenE (0x200) and PCSrcW (0x300) together, plus FlushD. Required:
  - The next address is 0x200.
  - InstrD = 0, ValidD = 0.
- PCF = 0xFFFF_FFFC with ready. Required: the next address is 0x0 and PCPlus8D = 0x4.
